wb_stream_slave: RTL
====================

// Module: wb_stream_slave
// PURPOSE
//  Wishbone slave that bridges the bus to a pair of 32-bit streams. Master writes to DATA push a TX FIFO drained on a
//  valid/ready output. Stream words arriving on a valid/ready input fill an RX FIFO that the master pops by reading
//  DATA. Sits on an interconnect slave slot beside device_rom_table / wb_ddr; the interrupt goes to the master.
// PARAMETERS
//  DEPTH_LOG2   4   log2 of each FIFO depth (16 words); legal range 1..7
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   reset, asynchronous, active-low (asserted at 0)
//  wbs_we_i     in   1   write enable
//  wbs_cyc_i    in   1   bus cycle
//  wbs_stb_i    in   1   strobe
//  wbs_sel_i    in   4   byte select; ignored, all accesses are full-word
//  wbs_adr_i    in   32  word address; only [1:0] decoded
//  wbs_dat_i    in   32  write data
//  wbs_dat_o    out  32  read data, valid while wbs_ack_o=1
//  wbs_ack_o    out  1   single-cycle acknowledge
//  wbs_int_o    out  1   interrupt, |(INT_STATUS & INT_EN)
//  tx_valid     out  1   TX FIFO not empty
//  tx_data      out  32  TX FIFO head word
//  tx_ready     in   1   sink accepts head word when tx_valid&tx_ready
//  rx_valid     in   1   source word present
//  rx_data      in   32  source word
//  rx_ready     out  1   RX FIFO not full
// BEHAVIOUR
//  Reset (rst=0, async): both FIFOs empty, wbs_ack_o=0, wbs_dat_o=0, INT_EN=0, sticky flags=0, wbs_int_o=0,
//   tx_valid=0, rx_ready=1. A bus cycle in flight during reset is dropped with no ack.
//  Register map by adr[1:0]:
//   0 DATA    W: push TX (wbs_dat_i). R: pop RX; returns head, or 0 if RX empty.
//   1 STATUS  R: [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [15:8]tx_count [23:16]rx_count, rest 0. W ignored.
//   2 INT_EN  R/W: [3:0] enables; [31:4] read 0.
//   3 INT_STS R: [0]rx_not_empty [1]tx_empty (level) [2]tx_ovf [3]rx_unf (sticky). W: 1 in [3:2] clears bit.
//  Handshake: request = cyc&stb&!ack. Sampled at edge N -> ack=1 at N+1 for exactly one cycle, then 0 for at least
//   one cycle. Side effects (push, pop, clear) occur at the same edge that raises ack. Read data registered with ack.
//  Write DATA with TX full: word dropped, tx_ovf set, ack still given. Read DATA with RX empty: returns 0, rx_unf
//   set, ack still given.
//  Full/empty judged on occupancy before the edge; no same-cycle pass-through:
//   - bus push to a full TX in the same cycle as a stream pop -> still dropped (tx_ovf).
//   - stream push into an empty RX in the same cycle as a bus pop -> read returns 0, word is stored.
//  Bus push and stream pop on TX in the same cycle (not full): count unchanged. Same for RX.
//  tx_valid rises the cycle after the first push. rx_ready=!rx_full, registered from occupancy.
//  Sticky set and W1C clear in the same cycle: set wins.
//  Pointers wrap modulo 2^DEPTH_LOG2; counts are DEPTH_LOG2+1 bits, zero-extended into STATUS.
//  wbs_int_o is a registered copy of |(INT_STS & INT_EN), updated every cycle.
// STRUCTURE
//  wb_stream_slave_defines.v: register addresses 0..3, STATUS/INT bit positions.
//  Sub-module wb_sfifo_core (sync FIFO: push, pop, data, count, full, empty), instanced twice for TX and RX.
//  Top level: bus decode/ack FSM (IDLE -> ACK -> IDLE), register file, sticky flag logic.
// TESTING
//  1 Write DATA 0xA5A5_0001, 0xA5A5_0002, tx_ready=1 -> tx_data 0xA5A5_0001 then 0xA5A5_0002; STATUS tx_empty=1.
//  2 tx_ready=0, write 17 words -> first 16 stored, STATUS[15:8]=0x10, tx_full=1; 17th dropped; INT_STS[2]=1.
//    Write INT_STS=0x4 -> bit 2 clears.
//  3 Drive rx 0x1234_5678, 0xDEAD_BEEF -> DATA reads return them in order. Third read returns 0 and sets INT_STS[3].
//  4 INT_EN=0x1, RX empty -> wbs_int_o=0. Push one rx word -> wbs_int_o=1 within 2 cycles; 0 after it is read.
//  5 Fill RX to 16 -> rx_ready=0 and the source holds. One DATA read -> rx_ready=1 next cycle, count 15->16 on refill.
//  6 Assert rst mid-write with stb held -> no ack; after release STATUS=0x0000_000A and wbs_int_o=0.

Source files
------------

// File: rtl/wb_stream_slave_pkg.sv
// Shared register addresses, interrupt bit positions and bus FSM states for the
// Wishbone-to-stream bridge.
package wb_stream_slave_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_INT_EN  = 2'd2;
    localparam logic [1:0] ADDR_INT_STS = 2'd3;

    localparam int INT_RX_NOT_EMPTY = 0;
    localparam int INT_TX_EMPTY     = 1;
    localparam int INT_TX_OVF       = 2;
    localparam int INT_RX_UNF       = 3;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    function automatic logic [31:0] pack_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_empty,
        input logic [7:0] tx_count,
        input logic [7:0] rx_count
    );
        return {8'h00, rx_count, tx_count, 4'h0, rx_empty, rx_full, tx_empty, tx_full};
    endfunction

endpackage

// File: rtl/wb_sfifo_core.sv
// Single-clock FIFO. Full/empty come from the registered count, so a push and a
// pop in the same cycle never observe each other's effect.
module wb_sfifo_core #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Count never exceeds DEPTH, so its top bit alone flags a full FIFO.
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_slave.sv
// Wishbone slave bridging the bus to a TX and an RX 32-bit valid/ready stream,
// with status, interrupt-enable and sticky interrupt-status registers.
module wb_stream_slave
    import wb_stream_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_int_o,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready
);
    localparam int CW = DEPTH_LOG2 + 1;

    bus_state_t  state;
    logic        bus_req;
    logic [1:0]  reg_sel;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        wr_int_en, wr_int_sts;
    logic [31:0] rx_head;
    logic [31:0] rd_word;
    logic [CW-1:0] tx_count, rx_count;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [3:0]  int_en;
    logic [3:0]  int_sts;
    logic        tx_ovf, rx_unf;
    logic        unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:2]};

    // A new request is only taken while ack is low, giving the mandatory idle cycle.
    assign bus_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign reg_sel    = wbs_adr_i[1:0];
    assign tx_push    = bus_req & wbs_we_i & (reg_sel == ADDR_DATA);
    assign rx_pop     = bus_req & ~wbs_we_i & (reg_sel == ADDR_DATA);
    assign wr_int_en  = bus_req & wbs_we_i & (reg_sel == ADDR_INT_EN);
    assign wr_int_sts = bus_req & wbs_we_i & (reg_sel == ADDR_INT_STS);

    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;

    wb_sfifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wbs_dat_i),
        .rdata(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    wb_sfifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
        .rdata(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        int_sts                   = '0;
        int_sts[INT_RX_NOT_EMPTY] = ~rx_empty;
        int_sts[INT_TX_EMPTY]     = tx_empty;
        int_sts[INT_TX_OVF]       = tx_ovf;
        int_sts[INT_RX_UNF]       = rx_unf;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            ADDR_DATA:    rd_word = rx_empty ? '0 : rx_head;
            ADDR_STATUS:  rd_word = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                                8'(tx_count), 8'(rx_count));
            ADDR_INT_EN:  rd_word = {28'h0, int_en};
            ADDR_INT_STS: rd_word = {28'h0, int_sts};
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BUS_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (bus_req) begin
                        state     <= BUS_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= wbs_we_i ? '0 : rd_word;
                    end
                end
                BUS_ACK: begin
                    state     <= BUS_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
                default: begin
                    state     <= BUS_IDLE;
                    wbs_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // A new overflow/underflow event in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_en    <= '0;
            tx_ovf    <= 1'b0;
            rx_unf    <= 1'b0;
            wbs_int_o <= 1'b0;
        end else begin
            if (wr_int_en) begin
                int_en <= wbs_dat_i[3:0];
            end
            tx_ovf    <= (tx_push & tx_full) | (tx_ovf & ~(wr_int_sts & wbs_dat_i[INT_TX_OVF]));
            rx_unf    <= (rx_pop & rx_empty) | (rx_unf & ~(wr_int_sts & wbs_dat_i[INT_RX_UNF]));
            wbs_int_o <= |(int_sts & int_en);
        end
    end

endmodule
